cart2600_type_resolve: RTL and testbench

Resolves the final 2600 bankswitch type for a cartridge as it is downloaded. The block sits directly downstream of the 2600 pattern detector and shares the cart download byte stream with it. It measures the cart image size, waits for the detector outputs to settle after the last byte, and merges three sources in fixed priority: filename-extension force, detector result, size default. It then latches a single mapper code, a Superchip enable and the image size for the 2600 cart mapper.

---
 rtl/cart2600_type_resolve.sv | 130 +++++++++++++
 tb/tb_cart2600_type_resolve.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cart2600_type_resolve.sv
// Resolves the 2600 bankswitch type for a downloaded cart. It merges the extension force,
// the detector result and a size default, then latches mapper code, Superchip enable and size.
module cart2600_type_resolve #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned SETTLE_CYC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [3:0]        ext_bs,
  input  logic [3:0]        det_bs,
  input  logic              det_sc,
  output logic [ADDR_W:0]   cart_size,
  output logic [3:0]        bs_type,
  output logic              sc_en,
  output logic              type_valid,
  output logic              resolve_done
);

  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RESOLVE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_dl_q;
  logic [ADDR_W-1:0] r_max_addr;
  logic              r_written;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_rise;
  logic              w_fall;
  logic [ADDR_W:0]   w_size;
  logic [63:0]       w_sz64;
  logic [3:0]        w_def;
  logic              w_det_ok;
  logic [3:0]        w_final;
  logic              w_sc;

  assign w_rise = ioctl_download & ~r_dl_q;
  assign w_fall = ~ioctl_download & r_dl_q;
  assign w_size = r_written ? ({1'b0, r_max_addr} + {{ADDR_W{1'b0}}, 1'b1}) : '0;
  assign w_sz64 = 64'(w_size);

  always_comb begin
    w_def = 4'd0;
    if (w_sz64 == 64'd8192)                            w_def = 4'd1;
    else if (w_sz64 >= 64'd10240 && w_sz64 <= 64'd10495) w_def = 4'd7;
    else if (w_sz64 == 64'd12288)                      w_def = 4'd8;
    else if (w_sz64 == 64'd16384)                      w_def = 4'd2;
    else if (w_sz64 == 64'd32768)                      w_def = 4'd6;
    else if (w_sz64 == 64'd65536)                      w_def = 4'd13;
    else if (w_sz64 > 64'd65536)                       w_def = 4'd5;

    // E7 and CV detections are only trusted for image sizes they can actually have
    w_det_ok = (det_bs != 4'd0);
    if (det_bs == 4'd12)
      w_det_ok = (w_sz64 == 64'd8192) || (w_sz64 == 64'd12288) || (w_sz64 == 64'd16384);
    else if (det_bs == 4'd9)
      w_det_ok = (w_sz64 <= 64'd4096);

    if (ext_bs != 4'd0)  w_final = ext_bs;
    else if (w_det_ok)   w_final = det_bs;
    else                 w_final = w_def;

    w_sc = det_sc && ((w_final == 4'd1) || (w_final == 4'd2) ||
                      (w_final == 4'd6) || (w_final == 4'd13));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      // Seed with the live input so a download already in progress is not seen as an edge
      r_dl_q       <= ioctl_download;
      r_max_addr   <= '0;
      r_written    <= 1'b0;
      r_cnt        <= '0;
      cart_size    <= '0;
      bs_type      <= '0;
      sc_en        <= 1'b0;
      type_valid   <= 1'b0;
      resolve_done <= 1'b0;
    end else begin
      r_dl_q       <= ioctl_download;
      resolve_done <= 1'b0;
      if (w_rise && r_state != S_LOAD) begin
        r_state    <= S_LOAD;
        r_max_addr <= '0;
        r_written  <= 1'b0;
        type_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_LOAD: begin
            if (ioctl_wr) begin
              if (ioctl_addr > r_max_addr) r_max_addr <= ioctl_addr;
              r_written <= 1'b1;
            end
            if (w_fall) begin
              r_state <= S_SETTLE;
              r_cnt   <= CNT_W'(SETTLE_CYC - 1);
            end
          end
          S_SETTLE: begin
            if (r_cnt == '0) r_state <= S_RESOLVE;
            else             r_cnt   <= r_cnt - 1'b1;
          end
          S_RESOLVE: begin
            cart_size    <= w_size;
            bs_type      <= w_final;
            sc_en        <= w_sc;
            type_valid   <= 1'b1;
            resolve_done <= 1'b1;
            r_state      <= S_DONE;
          end
          S_DONE: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cart2600_type_resolve.sv
// Randomized scoreboard bench for cart2600_type_resolve: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever resolve_done is seen.
module tb_cart2600_type_resolve;

  localparam int unsigned AW = 20;
  localparam int unsigned S  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [3:0]    ext_bs = '0;
  logic [3:0]    det_bs = '0;
  logic          det_sc = 1'b0;
  logic [AW:0]   cart_size;
  logic [3:0]    bs_type;
  logic          sc_en;
  logic          type_valid;
  logic          resolve_done;

  cart2600_type_resolve #(.ADDR_W(AW), .SETTLE_CYC(S)) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ext_bs(ext_bs), .det_bs(det_bs), .det_sc(det_sc),
    .cart_size(cart_size), .bs_type(bs_type), .sc_en(sc_en), .type_valid(type_valid),
    .resolve_done(resolve_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned size;
    longint unsigned bs;
    longint unsigned sc;
    longint unsigned due;
  } exp_t;

  exp_t            sbq[$];
  longint unsigned cyc = 0;
  int              checks = 0;
  int              failures = 0;
  logic            prev_done = 1'b0;
  exp_t            last_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mapper choice from the size/priority rules, written on plain integers
  function automatic longint unsigned ref_type(input longint unsigned sz, input int ext, input int det);
    int  dflt;
    bit  ok;
    case (1'b1)
      (sz == 8192):                  dflt = 1;
      (sz >= 10240 && sz < 10496):   dflt = 7;
      (sz == 12288):                 dflt = 8;
      (sz == 16384):                 dflt = 2;
      (sz == 32768):                 dflt = 6;
      (sz == 65536):                 dflt = 13;
      (sz > 65536):                  dflt = 5;
      default:                       dflt = 0;
    endcase
    ok = (det != 0);
    if (det == 12 && !(sz == 8192 || sz == 12288 || sz == 16384)) ok = 0;
    if (det == 9 && sz > 4096) ok = 0;
    if (ext != 0) return longint'(ext);
    if (ok) return longint'(det);
    return longint'(dflt);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_done) chk("resolve_done_width", resolve_done, 0);
      if (resolve_done) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resolve_done: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("cart_size", cart_size, e.size);
          chk("bs_type", bs_type, e.bs);
          chk("sc_en", sc_en, e.sc);
          chk("type_valid", type_valid, 1);
          chk("latency", cyc, e.due);
        end
      end
    end
    prev_done = resolve_done;
  end

  task automatic wait_result();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL result_timeout: got pending=%0d expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic dl(input int unsigned size, input int ext, input int det, input bit dsc,
                    input bit start_high, input bit last_on_fall, input bit stray);
    int unsigned addrs[$];
    longint unsigned mx = 0;
    bit   any = 0;
    exp_t e;
    ext_bs = 4'(ext);
    det_bs = 4'(det);
    det_sc = dsc;
    if (!start_high) begin
      ioctl_download = 1'b1;
      @(posedge clk); #1;
      chk("type_valid_drop", type_valid, 0);
    end
    if (size != 0) begin
      for (int i = 0; i < 16; i++) addrs.push_back($urandom_range(size - 1, 0));
      addrs.insert($urandom_range(16, 0), size - 1);
    end
    foreach (addrs[i]) begin
      if (addrs[i] > mx) mx = addrs[i];
      any = 1;
    end
    e.size = any ? mx + 1 : 0;
    e.bs   = ref_type(e.size, ext, det);
    e.sc   = (dsc && (e.bs == 1 || e.bs == 2 || e.bs == 6 || e.bs == 13)) ? 1 : 0;
    for (int i = 0; i < addrs.size(); i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = AW'(addrs[i]);
      if (last_on_fall && i == addrs.size() - 1) begin
        ioctl_download = 1'b0;
        e.due = cyc + S + 2;
        sbq.push_back(e);
      end
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
      if (!(last_on_fall && i == addrs.size() - 1))
        repeat ($urandom_range(1, 0)) begin @(posedge clk); #1; end
    end
    if (!(last_on_fall && addrs.size() != 0)) begin
      ioctl_download = 1'b0;
      e.due = cyc + S + 2;
      sbq.push_back(e);
      @(posedge clk); #1;
    end
    if (stray) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = '1;
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
    end
    last_exp = e;
    wait_result();
    @(posedge clk); #1;
    chk("type_valid_hold", type_valid, 1);
    chk("bs_type_hold", bs_type, last_exp.bs);
  endtask

  // Starts a download, ends it, then restarts it gap cycles later so the first never resolves
  task automatic partial(input int unsigned size, input int unsigned gap);
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = AW'($urandom_range(size - 1, 0));
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
    end
    ioctl_download = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    chk("abort_type_valid", type_valid, 0);
  endtask

  int unsigned pool[19] = '{0, 1, 2048, 4096, 4097, 8191, 8192, 10240, 10300, 10495, 10496,
                            12288, 16384, 32768, 65535, 65536, 65537, 131072, 1048576};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cart_size", cart_size, 0);
    chk("rst_bs_type", bs_type, 0);
    chk("rst_sc_en", sc_en, 0);
    chk("rst_type_valid", type_valid, 0);
    chk("rst_resolve_done", resolve_done, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    dl(8192, 0, 0, 0, 0, 0, 0);
    dl(16384, 0, 0, 1, 0, 0, 0);
    dl(16384, 12, 0, 1, 0, 1, 0);
    dl(4096, 0, 12, 0, 0, 0, 1);
    dl(8192, 0, 12, 0, 0, 0, 0);
    dl(10300, 0, 0, 0, 0, 1, 0);
    dl(131072, 0, 0, 0, 0, 0, 1);
    chk("size_131072", cart_size, 131072);
    dl(0, 3, 0, 1, 0, 0, 0);
    dl(4096, 0, 9, 0, 0, 0, 0);
    dl(4097, 0, 9, 0, 0, 0, 0);

    // Reset in the middle of a load; the still-high download must be ignored
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = AW'((i == 9) ? 4999 : $urandom_range(4998, 0));
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
    end
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    ioctl_download = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    chk("post_rst_type_valid", type_valid, 0);
    chk("post_rst_cart_size", cart_size, 0);
    chk("post_rst_bs_type", bs_type, 0);
    dl(32768, 0, 0, 0, 0, 0, 0);

    for (int g = 1; g <= 4; g++) begin
      partial(8192, g);
      dl(2048, 0, 0, 0, 1, 0, 0);
    end
    chk("final_2048_size", cart_size, 2048);

    for (int n = 0; n < 30; n++) begin
      int unsigned sz;
      int ext;
      sz  = ($urandom_range(4, 0) == 0) ? $urandom_range(1048576, 1) : pool[$urandom_range(18, 0)];
      ext = ($urandom_range(1, 0) == 1) ? 0 : $urandom_range(15, 1);
      if ($urandom_range(3, 0) == 0) begin
        partial(65536, $urandom_range(4, 1));
        dl(sz, ext, $urandom_range(15, 0), 1'($urandom_range(1, 0)), 1,
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end else begin
        dl(sz, ext, $urandom_range(15, 0), 1'($urandom_range(1, 0)), 0,
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end
    end

    repeat (10) @(posedge clk);
    #1;
    chk("queue_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
